input_ctrl: RTL and testbench
=============================

INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_packet, default 14, packet width in bits.
REQ-002 SHALL have parameter MY_ADDR, default 3'b000, this router's 3-bit node address.
REQ-003 SHALL have parameter MASK, default 3'b001, address bits that select the output side.
REQ-004 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, 2..16).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port in_data, input, WIDTH_packet, incoming packet; dest = in_data[13:11], payload = [10:0].
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), upstream handshake.
REQ-009 SHALL have port out0_data, output, WIDTH_packet, packet to output_ctrl port 0 (local side).
REQ-010 SHALL have ports out0_valid (output, 1) and out0_ready (input, 1), port-0 handshake.
REQ-011 SHALL have port out1_data, output, WIDTH_packet, packet to output_ctrl port 1 (far side).
REQ-012 SHALL have ports out1_valid (output, 1) and out1_ready (input, 1), port-1 handshake.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH)+1, current FIFO entry count.
REQ-014 SHALL have ports cnt0 and cnt1, output, 16 each, packets delivered on port 0 / port 1.

Function
REQ-015 SHALL complete a transfer on any channel only at a rising clk edge with valid and ready both high.
REQ-016 SHALL drive in_ready = (occupancy < DEPTH), from registered state only; no combinational path from any out*_ready.
REQ-017 SHALL write in_data to the FIFO tail on every input transfer; FIFO is strict FIFO order.
REQ-018 SHALL compute route = ((dest ^ MY_ADDR) & MASK) != 0: route 0 -> port 0, route 1 -> port 1.
REQ-019 SHALL hold a single output register with FSM states IDLE, HOLD0, HOLD1.
REQ-020 IDLE: if FIFO non-empty, pop head into output register and go to HOLD0/HOLD1 by route; else stay IDLE.
REQ-021 HOLDx: outx_valid = 1, outx_data = register, other port valid = 0; data stable until transfer.
REQ-022 HOLDx with outx_ready = 1: increment cntx; if FIFO non-empty, pop next head in same edge and go to HOLD by its route (back-to-back, 1 packet/cycle), else go IDLE.
REQ-023 HOLDx with outx_ready = 0: stay HOLDx; no pop; other port's ready is ignored.
REQ-024 Latency: packet written at edge N into empty FIFO with FSM IDLE SHALL show outx_valid = 1 after edge N+1.
REQ-025 Simultaneous push and pop in one edge SHALL leave occupancy unchanged; push while full SHALL not occur (in_ready = 0).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH exactly.
REQ-027 cnt0/cnt1 SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-028 The idle port's data output SHALL retain its last value (don't-care to consumers).

Reset
REQ-029 rst_n low SHALL immediately (no clock) force FSM IDLE, occupancy 0, pointers 0, in_ready 1 (combinational from reset state), out0_valid 0, out1_valid 0, out*_data 0, cnt0 0, cnt1 0.
REQ-030 Reset mid-operation SHALL discard all buffered and held packets; no counter increment for the discarded held packet.
REQ-031 First transfer SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-032 Routing: defaults, send 14'h0805 (dest 001) then 14'h1003 (dest 010), both readies 1 -> 0x0805 on port 1, then 0x1003 on port 0; cnt1 = 1, cnt0 = 1.
REQ-033 Backpressure/full: out0_ready = 0, send 6 packets dest 000 -> 1 held in HOLD0, 4 in FIFO, in_ready = 0, occupancy = 4; raise out0_ready -> all 5 delivered in order, one per cycle.
REQ-034 Head-of-line: held packet to port 0 with out0_ready = 0, next head routes to port 1 with out1_ready = 1 -> out1_valid stays 0 until port-0 transfer completes.
REQ-035 Throughput/wrap: stream 20 packets, all readies 1 -> 20 out, order preserved, occupancy never exceeds 2, pointers wrap.
REQ-036 Async reset: assert rst_n low between edges with occupancy 3 and HOLD1 -> all valids 0, occupancy 0, counters 0 before next edge; post-reset packet delivered normally.
REQ-037 Counter wrap: preload via 65536 port-0 deliveries -> cnt0 reads 0.

Source files
------------

// File: rtl/input_ctrl.sv
// Router input controller: buffers incoming packets in a FIFO and presents the
// head, one at a time, to the local (port 0) or far (port 1) output controller.
module input_ctrl #(
  parameter int         WIDTH_packet = 14,
  parameter logic [2:0] MY_ADDR      = 3'b000,
  parameter logic [2:0] MASK         = 3'b001,
  parameter int         DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH_packet-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH_packet-1:0]   out0_data,
  output logic                      out0_valid,
  input  logic                      out0_ready,
  output logic [WIDTH_packet-1:0]   out1_data,
  output logic                      out1_valid,
  input  logic                      out1_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               cnt0,
  output logic [15:0]               cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t                  state, next_state;
  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [WIDTH_packet-1:0] head;
  logic                    fifo_empty;
  logic                    push, pop, head_route;
  logic                    deliver0, deliver1;

  // Routing looks only at the address bits selected by MASK
  function automatic logic route_of(input logic [WIDTH_packet-1:0] pkt);
    return |((pkt[WIDTH_packet-1 -: 3] ^ MY_ADDR) & MASK);
  endfunction

  assign head       = mem[rd_ptr];
  assign head_route = route_of(head);
  assign fifo_empty = (occupancy == '0);
  assign in_ready   = (occupancy < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign out0_valid = (state == HOLD0);
  assign out1_valid = (state == HOLD1);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    deliver0   = 1'b0;
    deliver1   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      HOLD0: begin
        if (out0_ready) begin
          deliver0 = 1'b1;
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      HOLD1: begin
        if (out1_ready) begin
          deliver1 = 1'b1;
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // A pop always re-targets the FSM at the new packet's port
    if (pop) next_state = head_route ? HOLD1 : HOLD0;
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out0_data <= '0;
      out1_data <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      // Each port keeps its last packet while the other port is in use
      if (pop && !head_route) out0_data <= head;
      if (pop &&  head_route) out1_data <= head;
      if (deliver0) cnt0 <= cnt0 + 16'd1;
      if (deliver1) cnt1 <= cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Self-checking bench for input_ctrl: a negedge monitor scores every output
// transfer against a queue of expected packets filled as inputs are accepted.
module tb_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [2:0]  occupancy;
  logic [15:0] cnt0, cnt1;

  typedef struct {
    logic [13:0] data;
    logic        port;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   delivered = 0;
  int   max_occ = 0;

  input_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .occupancy(occupancy), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic exp_route(input logic [13:0] d);
    return ((d[13:11] ^ 3'b000) & 3'b001) != 3'b000;
  endfunction

  // Scoreboard monitor: inputs are stable at negedge, so what is seen here is
  // exactly what the following rising edge will transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out0_valid && out1_valid) begin
        vectors++; miscompares++;
        $display("[TB] FAIL both_valid: got 11 expected one-hot");
      end
      if (out0_valid && out0_ready) begin
        vectors++; delivered++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL port0_unexpected: got %h expected nothing", out0_data);
        end else begin
          e = sb.pop_front();
          if (e.port !== 1'b0 || out0_data !== e.data) begin
            miscompares++;
            $display("[TB] FAIL port0_data: got %h on port 0 expected %h on port %0d",
                     out0_data, e.data, e.port);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        vectors++; delivered++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL port1_unexpected: got %h expected nothing", out1_data);
        end else begin
          e = sb.pop_front();
          if (e.port !== 1'b1 || out1_data !== e.data) begin
            miscompares++;
            $display("[TB] FAIL port1_data: got %h on port 1 expected %h on port %0d",
                     out1_data, e.data, e.port);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = in_data;
        e.port = exp_route(in_data);
        sb.push_back(e);
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
  end

  // Drives one packet; must be entered just after a rising edge
  task automatic send(input logic [13:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        vectors++; miscompares++;
        $display("[TB] FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb.size() != 0 || out0_valid || out1_valid) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    vectors++;
    if (t >= budget) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if (occupancy !== 3'd0 || in_ready !== 1'b1 || out0_valid !== 1'b0 ||
        out1_valid !== 1'b0 || out0_data !== 14'h0 || out1_data !== 14'h0 ||
        cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got occ=%0d rdy=%b v=%b%b d0=%h d1=%h c0=%0d c1=%0d expected all 0 with rdy=1",
               occupancy, in_ready, out1_valid, out0_valid, out0_data, out1_data, cnt0, cnt1);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(14'h0805);
    send(14'h1003);
    drain(50);
    vectors++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL routing_counts: got cnt0=%0d cnt1=%0d expected 1 and 1", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0; out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(14'h0010 + 14'(i));
    @(negedge clk);
    vectors++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 14'h0010) begin
      miscompares++;
      $display("[TB] FAIL full_state: got occ=%0d rdy=%b v0=%b d0=%h expected occ=4 rdy=0 v0=1 d0=0010",
               occupancy, in_ready, out0_valid, out0_data);
    end
    @(posedge clk); #1;
    in_data = 14'h0015; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (occupancy !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL push_when_full: got occ=%0d expected 4", occupancy);
    end
    out0_ready = 1'b1;
    fork
      send(14'h0015);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          vectors++;
          if (out0_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got out0_valid 0 expected 1 at cycle %0d", k);
          end
        end
      end
    join
    @(posedge clk); #1;
    drain(50);
  endtask

  task automatic test_head_of_line();
    out0_ready = 1'b0; out1_ready = 1'b1;
    send(14'h0022);
    send(14'h0833);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out1_valid !== 1'b0 || out0_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL head_of_line: got v1=%b v0=%b expected v1=0 v0=1", out1_valid, out0_valid);
      end
    end
    @(posedge clk); #1;
    out0_ready = 1'b1;
    drain(50);
  endtask

  task automatic test_throughput();
    int start;
    logic [31:0] r;
    out0_ready = 1'b1; out1_ready = 1'b1;
    max_occ = 0;
    start = delivered;
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      send(r[13:0]);
    end
    drain(100);
    vectors++;
    if (delivered - start != 20 || max_occ > 2) begin
      miscompares++;
      $display("[TB] FAIL throughput: got %0d out max_occ=%0d expected 20 out max_occ<=2",
               delivered - start, max_occ);
    end
  endtask

  task automatic test_async_reset();
    out0_ready = 1'b1; out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(14'h0840 + 14'(i));
    @(negedge clk);
    vectors++;
    if (occupancy !== 3'd3 || out1_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset: got occ=%0d v1=%b expected occ=3 v1=1", occupancy, out1_valid);
    end
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || occupancy !== 3'd0 ||
        in_ready !== 1'b1 || cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got v=%b%b occ=%0d rdy=%b c0=%0d c1=%0d expected all 0 rdy=1",
               out1_valid, out0_valid, occupancy, in_ready, cnt0, cnt1);
    end
    out1_ready = 1'b1;
    #1 rst_n = 1'b1;
    in_data = 14'h0805; in_valid = 1'b1;
    begin
      exp_t e;
      e.data = 14'h0805; e.port = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (occupancy !== 3'd1 || out1_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_accept: got occ=%0d v1=%b expected occ=1 v1=0", occupancy, out1_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 14'h0805) begin
      miscompares++;
      $display("[TB] FAIL latency: got v1=%b d1=%h expected v1=1 d1=0805", out1_valid, out1_data);
    end
    drain(50);
    vectors++;
    if (cnt1 !== 16'd1 || cnt0 !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_counts: got cnt0=%0d cnt1=%0d expected 0 and 1", cnt0, cnt1);
    end
  endtask

  task automatic test_counter_wrap();
    int start;
    logic [31:0] idx;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    start = delivered;
    for (int i = 0; i < 65536; i++) begin
      idx = i;
      send({3'b000, idx[10:0]});
      if (i == 65534) begin
        vectors++;
        if (cnt0 !== 16'hFFFE && cnt0 !== 16'hFFFD) begin
          miscompares++;
          $display("[TB] FAIL cnt0_near_wrap: got %h expected FFFD or FFFE", cnt0);
        end
      end
    end
    drain(50);
    vectors++;
    if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000 || delivered - start != 65536) begin
      miscompares++;
      $display("[TB] FAIL counter_wrap: got cnt0=%h cnt1=%h n=%0d expected 0000 0000 65536",
               cnt0, cnt1, delivered - start);
    end
  endtask

  initial begin
    $display("[TB] starting input_ctrl bench");
    test_reset();
    test_routing();
    test_backpressure();
    test_head_of_line();
    test_throughput();
    test_async_reset();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
